adc_tape_slicer: RTL and testbench
==================================

Name: adc_tape_slicer

Overview:
- Sits between the ltc2308 ADC interface and the dragoncoco cassette input (casdout path when Tape Input = ADC).
- Detects each new ADC sample, tracks a 2^DEPTH_LOG2-sample running average in a ring buffer (high-pass around 100 Hz), and slices the sample into a 1-bit cassette level with hysteresis.
- Also exports the latched sample, used for cass_snd and tape-monitor audio.

Parameters:
- SAMPLE_W, 12, ADC sample width.
- DEPTH_LOG2, 9, log2 of averaging window; 512 samples.
- HYST, 100, hysteresis threshold in ADC LSBs (about 0.1 V).

Ports:
- clk  in  1  system clock; CLK_50M domain at top level.
- reset  in  1  synchronous, active-high.
- adc_data  in  SAMPLE_W  ADC sample; valid when adc_sync toggles.
- adc_sync  in  1  toggles once per new sample (ltc2308 dout_sync).
- sample_out  out  SAMPLE_W  last accepted sample.
- avg_out  out  SAMPLE_W  current window average.
- cas_bit  out  1  sliced tape level; polarity inverted as on the original CoCo.
- sample_stb  out  1  one-cycle pulse when sample_out, avg_out and cas_bit update.
- overrun  out  1  sticky; a sample toggle was dropped.

Behaviour:
- Reset values: sample_out=0, avg_out=0, cas_bit=0, sample_stb=0, overrun=0. Internally: total=0, wr_ptr=0, primed=0, sync_d=adc_sync, FSM=IDLE, pending=0.
- Edge detect: sync_d <= adc_sync every cycle; new = sync_d ^ adc_sync.
- FSM states and transitions:
  - IDLE: if new or pending, latch adc_data into sample_reg, issue RAM read at wr_ptr, clear pending -> RD.
  - RD: old = primed ? ram_q : 0; write sample_reg to RAM[wr_ptr]; total <= total - old + sample_reg; wr_ptr <= wr_ptr + 1 (mod 2^DEPTH_LOG2). If wr_ptr was all-ones, primed <= 1. -> CMP.
  - CMP: avg = total[SAMPLE_W+DEPTH_LOG2-1 : DEPTH_LOG2], using the total updated in RD. Compare in signed SAMPLE_W+2 bits, no wrap:
    - sample_reg < avg - HYST -> cas_bit=1.
    - sample_reg > avg + HYST -> cas_bit=0.
    - otherwise hold cas_bit.
    - Register sample_out, avg_out, cas_bit; assert sample_stb. -> IDLE.
- Latency: detection cycle t (IDLE) -> outputs valid with sample_stb high at t+3.
- Width: total is SAMPLE_W+DEPTH_LOG2 bits (21 by default). Unsigned; never over- or underflows, because old is always a value previously added.
- Priming: for the first 2^DEPTH_LOG2 samples after reset, evicted values are 0. The average ramps up; RAM contents are never cleared.
- Toggle during RD/CMP: set pending, served on the next IDLE. Toggle while pending already set: dropped, overrun <= 1. overrun clears only on reset.
- Near the thresholds: avg < HYST gives a negative lower threshold, so the bit never goes 1 from that compare. avg + HYST > 2^SAMPLE_W-1 is not clamped.
- Reset mid-operation: FSM -> IDLE, pending dropped, partial accumulation discarded, primed=0.
- Single-port RAM, 2^DEPTH_LOG2 x SAMPLE_W, 1-cycle registered read.

Optional Feature:
- Macro: ADC_TAPE_GLITCH_FILTER_EN.
- Defined: cas_bit changes only after two consecutive CMP evaluations demand the same new level. A one-bit "armed" register holds the candidate and clears on any non-agreeing or hold result; reset clears it. Latency from the first crossing is therefore two samples.
- Undefined: a single crossing changes cas_bit immediately. Ports are identical in both builds.

Decomposition:
- Package adc_tape_pkg:
  - constants SAMPLE_W_DEF, DEPTH_LOG2_DEF, HYST_DEF;
  - slicer_state_t enum {IDLE, RD, CMP};
  - function avg_of(total) for the shift/truncate.
- Sub-module adc_tape_ring: parameterised single-port ring RAM with registered read, inferable as M10K.

Test Plan:
- Reset, then constant adc_data=2048 toggled 600 times -> avg_out ramps and reaches 2048 after sample 512; cas_bit stays 0; sample_stb pulses exactly 3 cycles after each toggle edge.
- Prime 512 samples at 2000, then 1850 -> cas_bit=1. Then 2050 -> cas_bit stays 1 (inside hysteresis). Then 2150 -> cas_bit=0.
- Two toggles 1 cycle apart -> both samples processed (pending used), overrun=0. Three toggles within 3 cycles -> overrun=1 and stays 1 until reset.
- Prime at 50, then sample 0 -> avg - HYST is negative; cas_bit must not become 1 (checks no unsigned wrap).
- Assert reset during RD -> next cycle: outputs 0, FSM IDLE. The next toggle restarts priming from total=0.
- With ADC_TAPE_GLITCH_FILTER_EN, on a 2000 baseline: single sample 1850 then 2000 -> cas_bit stays 0. Two consecutive 1850s -> cas_bit=1 on the second sample_stb.

Source files
------------

// File: rtl/adc_tape_slicer_pkg.sv
//------------------------------------------------------------------------------
// Module   : adc_tape_pkg
// Brief    : Shared constants, FSM state type and averaging helper for the
//            ADC cassette slicer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package adc_tape_pkg;

  localparam int SAMPLE_W_DEF   = 12;
  localparam int DEPTH_LOG2_DEF = 9;
  localparam int HYST_DEF       = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2
  } slicer_state_t;

  // Window average is the running total divided by the window size; callers
  // truncate the result to the sample width.
  function automatic logic [31:0] avg_of(input logic [31:0] total,
                                         input int unsigned shift);
    return total >> shift;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_tape_slicer_if.sv
//------------------------------------------------------------------------------
// Module   : adc_tape_slicer_if
// Brief    : ADC sample input and sliced tape output bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface adc_tape_slicer_if
  import adc_tape_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
);

  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_sync;
  logic [SAMPLE_W-1:0] sample_out;
  logic [SAMPLE_W-1:0] avg_out;
  logic                cas_bit;
  logic                sample_stb;
  logic                overrun;

  modport master (
    output adc_data, adc_sync,
    input  sample_out, avg_out, cas_bit, sample_stb, overrun
  );

  modport slave (
    input  adc_data, adc_sync,
    output sample_out, avg_out, cas_bit, sample_stb, overrun
  );

endinterface

`default_nettype wire

// File: rtl/adc_tape_ring.sv
//------------------------------------------------------------------------------
// Module   : adc_tape_ring
// Brief    : Single-port ring RAM with registered read (block-RAM inferable).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adc_tape_ring
  import adc_tape_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  wire logic                  clk,
  input  wire logic                  we_i,
  input  wire logic [DEPTH_LOG2-1:0] addr_i,
  input  wire logic [WIDTH-1:0]      wdata_i,
  output logic      [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the RAM maps onto a block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/adc_tape_slicer.sv
//------------------------------------------------------------------------------
// Module   : adc_tape_slicer
// Brief    : Slices ADC samples into a cassette bit against a running window
//            average with hysteresis. Optional: ADC_TAPE_GLITCH_FILTER_EN
//            requires two agreeing crossings before cas_bit changes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adc_tape_slicer
  import adc_tape_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int HYST       = HYST_DEF
) (
  input wire logic        clk,
  input wire logic        reset,
  adc_tape_slicer_if.slave bus
);

  localparam int TOT_W = SAMPLE_W + DEPTH_LOG2;
  localparam int CW    = SAMPLE_W + 2;

  slicer_state_t         state_q, state_d;
  logic                  sync_q;
  logic [SAMPLE_W-1:0]   sample_reg_q, sample_reg_d;
  logic [TOT_W-1:0]      total_q, total_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                  primed_q, primed_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic [SAMPLE_W-1:0]   sample_out_q, sample_out_d;
  logic [SAMPLE_W-1:0]   avg_out_q, avg_out_d;
  logic                  cas_q, cas_d;
  logic                  stb_q, stb_d;
`ifdef ADC_TAPE_GLITCH_FILTER_EN
  logic                  armed_q, armed_d;
`endif

  logic                  w_new;
  logic                  w_ram_we;
  logic [SAMPLE_W-1:0]   w_ram_q;
  logic [SAMPLE_W-1:0]   w_old;
  logic [SAMPLE_W-1:0]   w_avg;
  logic signed [CW-1:0]  w_s, w_a, w_h, w_lo, w_hi;
  logic                  w_want_set, w_want_clr;

  assign w_new = sync_q ^ bus.adc_sync;
  assign w_old = primed_q ? w_ram_q : '0;
  assign w_avg = SAMPLE_W'(avg_of(32'(total_q), DEPTH_LOG2));

  // Zero-extended signed compare so avg - HYST can go negative without wrap.
  assign w_s        = $signed({2'b00, sample_reg_q});
  assign w_a        = $signed({2'b00, w_avg});
  assign w_h        = $signed(CW'(HYST));
  assign w_lo       = w_a - w_h;
  assign w_hi       = w_a + w_h;
  assign w_want_set = (w_s < w_lo);
  assign w_want_clr = (w_s > w_hi);

  adc_tape_ring #(
    .WIDTH      (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ring (
    .clk     (clk),
    .we_i    (w_ram_we),
    .addr_i  (wr_ptr_q),
    .wdata_i (sample_reg_q),
    .rdata_o (w_ram_q)
  );

  always_ff @(posedge clk) begin
    sync_q <= bus.adc_sync;
    if (reset) begin
      state_q      <= IDLE;
      sample_reg_q <= '0;
      total_q      <= '0;
      wr_ptr_q     <= '0;
      primed_q     <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      sample_out_q <= '0;
      avg_out_q    <= '0;
      cas_q        <= 1'b0;
      stb_q        <= 1'b0;
`ifdef ADC_TAPE_GLITCH_FILTER_EN
      armed_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sample_reg_q <= sample_reg_d;
      total_q      <= total_d;
      wr_ptr_q     <= wr_ptr_d;
      primed_q     <= primed_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      sample_out_q <= sample_out_d;
      avg_out_q    <= avg_out_d;
      cas_q        <= cas_d;
      stb_q        <= stb_d;
`ifdef ADC_TAPE_GLITCH_FILTER_EN
      armed_q      <= armed_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_reg_d = sample_reg_q;
    total_d      = total_q;
    wr_ptr_d     = wr_ptr_q;
    primed_d     = primed_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    sample_out_d = sample_out_q;
    avg_out_d    = avg_out_q;
    cas_d        = cas_q;
    stb_d        = 1'b0;
    w_ram_we     = 1'b0;
`ifdef ADC_TAPE_GLITCH_FILTER_EN
    armed_d      = armed_q;
`endif

    // A toggle arriving mid-update is queued once; a second one is lost.
    if (state_q != IDLE && w_new) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (w_new || pending_q) begin
          sample_reg_d = bus.adc_data;
          pending_d    = 1'b0;
          state_d      = RD;
        end
      end
      RD: begin
        w_ram_we = 1'b1;
        total_d  = total_q - TOT_W'(w_old) + TOT_W'(sample_reg_q);
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (&wr_ptr_q) begin
          primed_d = 1'b1;
        end
        state_d = CMP;
      end
      CMP: begin
`ifdef ADC_TAPE_GLITCH_FILTER_EN
        if ((w_want_set && !cas_q) || (w_want_clr && cas_q)) begin
          if (armed_q) begin
            cas_d   = ~cas_q;
            armed_d = 1'b0;
          end else begin
            armed_d = 1'b1;
          end
        end else begin
          armed_d = 1'b0;
        end
`else
        if (w_want_set) begin
          cas_d = 1'b1;
        end else if (w_want_clr) begin
          cas_d = 1'b0;
        end
`endif
        sample_out_d = sample_reg_q;
        avg_out_d    = w_avg;
        stb_d        = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sample_out = sample_out_q;
  assign bus.avg_out    = avg_out_q;
  assign bus.cas_bit    = cas_q;
  assign bus.sample_stb = stb_q;
  assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_tape_slicer.sv
//------------------------------------------------------------------------------
// Module   : tb_adc_tape_slicer
// Brief    : Directed self-checking bench for adc_tape_slicer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_adc_tape_slicer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   stb_cnt;

  adc_tape_slicer_if #(.SAMPLE_W(12)) bus ();

  adc_tape_slicer #(
    .SAMPLE_W   (12),
    .DEPTH_LOG2 (9),
    .HYST       (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Toggle at a negedge; outputs are due after the third following posedge.
  task automatic send_sample(input logic [11:0] v, input bit timing);
    @(negedge clk);
    bus.adc_data = v;
    bus.adc_sync = ~bus.adc_sync;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (timing) check("stb_timing", bus.sample_stb, (i == 3));
    end
  endtask

  task automatic toggle(input logic [11:0] v);
    @(negedge clk);
    bus.adc_data = v;
    bus.adc_sync = ~bus.adc_sync;
  endtask

  task automatic count_stb(input int cycles);
    stb_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.sample_stb) stb_cnt++;
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bus.adc_data = '0;
    bus.adc_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", bus.sample_out, 0);
    check("rst_avg", bus.avg_out, 0);
    check("rst_cas", bus.cas_bit, 0);
    check("rst_stb", bus.sample_stb, 0);
    check("rst_ovr", bus.overrun, 0);
    @(negedge clk);
    reset = 1'b0;

    // Constant 2048: avg ramps by 4 per sample, then settles.
    for (int k = 1; k <= 600; k++) begin
      send_sample(12'd2048, (k <= 3) || (k == 600));
      if (k == 1)   check("ramp_avg1", bus.avg_out, 4);
      if (k == 256) check("ramp_avg256", bus.avg_out, 1024);
      if (k == 512) check("ramp_avg512", bus.avg_out, 2048);
      if (k == 300) check("ramp_cas300", bus.cas_bit, 0);
    end
    check("const_avg600", bus.avg_out, 2048);
    check("const_cas600", bus.cas_bit, 0);
    check("const_sample", bus.sample_out, 2048);

    // Hysteresis around a 2000 baseline.
    do_reset();
    for (int k = 0; k < 512; k++) send_sample(12'd2000, 1'b0);
    check("base_avg", bus.avg_out, 2000);
    check("base_cas", bus.cas_bit, 0);
`ifdef ADC_TAPE_GLITCH_FILTER_EN
    send_sample(12'd1850, 1'b0);
    check("gf_single_cas", bus.cas_bit, 0);
    check("gf_single_avg", bus.avg_out, 1999);
    send_sample(12'd2000, 1'b0);
    check("gf_back_cas", bus.cas_bit, 0);
    send_sample(12'd1850, 1'b0);
    check("gf_first_cas", bus.cas_bit, 0);
    send_sample(12'd1850, 1'b0);
    check("gf_second_cas", bus.cas_bit, 1);
    send_sample(12'd2050, 1'b0);
    check("gf_hold_cas", bus.cas_bit, 1);
    send_sample(12'd2150, 1'b0);
    check("gf_hi1_cas", bus.cas_bit, 1);
    send_sample(12'd2150, 1'b0);
    check("gf_hi2_cas", bus.cas_bit, 0);
    check("gf_hi2_avg", bus.avg_out, 1999);
`else
    send_sample(12'd1850, 1'b0);
    check("low_cas", bus.cas_bit, 1);
    check("low_avg", bus.avg_out, 1999);
    check("low_sample", bus.sample_out, 1850);
    send_sample(12'd2050, 1'b0);
    check("hold_cas", bus.cas_bit, 1);
    check("hold_avg", bus.avg_out, 1999);
    send_sample(12'd2150, 1'b0);
    check("high_cas", bus.cas_bit, 0);
    check("high_avg", bus.avg_out, 2000);
`endif

    // Reset while the FSM sits in RD.
    toggle(12'd1234);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rd_rst_sample", bus.sample_out, 0);
    check("rd_rst_avg", bus.avg_out, 0);
    check("rd_rst_cas", bus.cas_bit, 0);
    check("rd_rst_stb", bus.sample_stb, 0);
    @(negedge clk);
    reset = 1'b0;
    count_stb(5);
    check("rd_rst_no_stb", stb_cnt, 0);
    send_sample(12'd1000, 1'b1);
    check("restart_avg", bus.avg_out, 1);
    check("restart_sample", bus.sample_out, 1000);

    // Two toggles one cycle apart: second one is served from pending.
    toggle(12'd100);
    toggle(12'd200);
    count_stb(12);
    check("pend_stb_cnt", stb_cnt, 2);
    check("pend_sample", bus.sample_out, 200);
    check("pend_ovr", bus.overrun, 0);

    // Three toggles in three cycles: third is dropped.
    toggle(12'd10);
    toggle(12'd20);
    toggle(12'd30);
    count_stb(12);
    check("ovr_stb_cnt", stb_cnt, 2);
    check("ovr_set", bus.overrun, 1);
    send_sample(12'd300, 1'b0);
    check("ovr_sticky", bus.overrun, 1);
    check("ovr_sample", bus.sample_out, 300);
    do_reset();
    #1;
    check("ovr_cleared", bus.overrun, 0);

    // Low baseline: avg - HYST negative must not trip the low threshold.
    for (int k = 0; k < 512; k++) send_sample(12'd50, 1'b0);
    check("low_base_avg", bus.avg_out, 50);
    send_sample(12'd0, 1'b0);
    check("neg_thr_cas", bus.cas_bit, 0);
    check("neg_thr_avg", bus.avg_out, 49);
    send_sample(12'd0, 1'b0);
    check("neg_thr_cas2", bus.cas_bit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
